uart_tx_ctrl: RTL



---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_gen.sv | 32 +++
 rtl/uart_tx_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit timing and line levels.
// Both the TX and RX sides import this package.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int DEF_CLKS_PER_BIT = 434;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  // Keeps only the low data_bits bits of a byte.
  function automatic logic [7:0] data_mask(input int data_bits);
    return 8'hFF >> (8 - data_bits);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and pulses bit_tick
// in the last cycle of each bit period.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign bit_tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// Framed UART transmitter: accepts a byte per valid/ready handshake and sends
// start, LSB-first data, optional parity and 1-2 stop bits on a registered line.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  // Handshake: a byte transfers on any rising edge where tx_valid && tx_ready;
  // tx_ready depends only on FSM state and counters, and upstream must hold
  // tx_data/tx_valid stable until that edge.

  generate
    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 8 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
      $error("uart_tx_ctrl: illegal parameter value");
    end
  endgenerate

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic [7:0] MASK      = data_mask(DATA_BITS);

  uart_state_e state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        parity_q, parity_d;
  logic        tx_q, tx_d;
  logic        bit_tick;
  logic        frame_end;
  logic        accept;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (accept),
    .en       (state_q != ST_IDLE),
    .bit_tick (bit_tick)
  );

  // The last cycle of the final stop bit doubles as the next accept slot.
  assign frame_end = (state_q == ST_STOP) && bit_tick && (bit_cnt_q == LAST_STOP);
  assign tx_ready  = (state_q == ST_IDLE) || frame_end;
  assign busy      = !tx_ready;
  assign tx_done   = frame_end;
  assign accept    = tx_valid && tx_ready;
  assign tx        = tx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      tx_q      <= LINE_IDLE;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    tx_d      = tx_q;

    case (state_q)
      ST_IDLE: ;
      ST_START: begin
        if (bit_tick) begin
          state_d   = ST_DATA;
          tx_d      = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            if (PARITY_EN != 0) begin
              state_d = ST_PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = STOP_LVL;
            end
          end else begin
            tx_d      = shreg_q[0];
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          state_d   = ST_STOP;
          tx_d      = STOP_LVL;
          bit_cnt_d = '0;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          if (bit_cnt_q == LAST_STOP) begin
            state_d = ST_IDLE;
            tx_d    = LINE_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = LINE_IDLE;
      end
    endcase

    // An accept overrides the return to IDLE so frames run back to back.
    if (accept) begin
      state_d   = ST_START;
      tx_d      = START_LVL;
      shreg_d   = tx_data & MASK;
      parity_d  = (^(tx_data & MASK)) ^ (PARITY_ODD != 0);
      bit_cnt_d = '0;
    end
  end

endmodule
